// File: rtl/ahb_slave_mem.sv
// AHB-lite memory responder: decodes an address window and serves single and
// burst transfers from word-organised storage, with optional wait states and two-cycle ERROR responses.
module ahb_slave_mem #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int          MEM_DEPTH   = 256,
   parameter int          WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   localparam int          IDX_W      = $clog2(MEM_DEPTH);
   localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(4 * MEM_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      DATA,
      ERR1,
      ERR2
   } state_e;

   state_e           state_q, state_d;
   state_e           firstState;
   logic [3:0]       waitCnt_q, waitCnt_d;
   logic [IDX_W-1:0] wordIdx_q;
   logic [1:0]       byteOff_q;
   logic [1:0]       size_q;
   logic             write_q;
   logic [31:0]      mem [MEM_DEPTH];

   logic             accept;
   logic             inRange;
   logic             legal;
   logic [3:0]       byteEn;
   logic             unusedInputs;

   assign unusedInputs = ^{hburst, htrans[0]};

   // Only take a new address phase while this slave is itself ready.
   assign accept  = hsel & hready & htrans[1] & hreadyout;
   assign inRange = ({1'b0, haddr} >= {1'b0, ADDR_BASE}) && ({1'b0, haddr} < ADDR_LIMIT);

   always_comb begin
      legal = inRange;
      case (hsize)
         3'd0:    legal = inRange;
         3'd1:    if (haddr[0]) legal = 1'b0;
         3'd2:    if (haddr[1:0] != 2'b00) legal = 1'b0;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      firstState = DATA;
      if (!legal)               firstState = ERR1;
      else if (WAIT_STATES > 0) firstState = WAIT;
   end

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      case (state_q)
         IDLE, DATA, ERR2: begin
            if (accept) begin
               state_d   = firstState;
               waitCnt_d = legal ? 4'(WAIT_STATES) : 4'd0;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (waitCnt_q <= 4'd1) begin
               state_d   = DATA;
               waitCnt_d = 4'd0;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         wordIdx_q <= '0;
         byteOff_q <= 2'b00;
         size_q    <= 2'b00;
         write_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         if (accept) begin
            wordIdx_q <= IDX_W'((haddr - ADDR_BASE) >> 2);
            byteOff_q <= haddr[1:0];
            size_q    <= hsize[1:0];
            write_q   <= hwrite;
         end
      end
   end

   always_comb begin
      case (size_q)
         2'd0:    byteEn = 4'b0001 << byteOff_q;
         2'd1:    byteEn = byteOff_q[1] ? 4'b1100 : 4'b0011;
         default: byteEn = 4'b1111;
      endcase
   end

   // Storage is deliberately not reset; writes land at the end of the DATA cycle.
   always_ff @(posedge hclk) begin
      if (state_q == DATA && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) mem[wordIdx_q][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

   assign hreadyout = !(state_q == WAIT || state_q == ERR1);
   assign hresp     = (state_q == ERR1 || state_q == ERR2);
   assign hrdata    = ((state_q == WAIT || state_q == DATA) && !write_q) ? mem[wordIdx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: the driver pushes expected responses from a
// byte-level memory model, and a bus monitor pops and compares them as data phases complete.
module tb_ahb_slave_mem;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 16;
   localparam int          WS    = 2;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   typedef struct {
      bit          err;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] model [DEPTH];
   int          compared = 0;
   int          mismatched = 0;

   always #5 hclk = ~hclk;
   assign hready = hreadyout;

   ahb_slave_mem #(
      .ADDR_BASE  (BASE),
      .MEM_DEPTH  (DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .hsel     (hsel),
      .haddr    (haddr),
      .htrans   (htrans),
      .hwrite   (hwrite),
      .hsize    (hsize),
      .hburst   (hburst),
      .hwdata   (hwdata),
      .hready   (hready),
      .hreadyout(hreadyout),
      .hresp    (hresp),
      .hrdata   (hrdata)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit isLegal(input logic [31:0] a, input logic [2:0] s);
      if (s > 3'd2) return 1'b0;
      if (s == 3'd1 && a[0]) return 1'b0;
      if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
      if (a < BASE || a >= BASE + 32'(4 * DEPTH)) return 1'b0;
      return 1'b1;
   endfunction

   // One address phase; the expectation is queued before the bus can accept it.
   task automatic applyStimulus(input logic [31:0] a, input bit w, input logic [2:0] s,
                                input logic [1:0] t, input logic [31:0] wd, input bit sel,
                                input bit commit);
      exp_t        e;
      int          n;
      int          idx;
      int          nb;
      int          first;
      logic [31:0] word;
      hsel   = sel;
      haddr  = a;
      hwrite = w;
      hsize  = s;
      htrans = t;
      hburst = 3'b001;
      if (sel && t[1]) begin
         e.err   = !isLegal(a, s);
         e.waits = e.err ? 1 : WS;
         e.rdata = 32'h0;
         if (!e.err) begin
            idx  = int'((a - BASE) / 4);
            word = model[idx];
            if (!w) begin
               e.rdata = word;
            end else if (commit) begin
               nb    = 1 << s;
               first = int'(a % 4);
               for (int k = 0; k < nb; k++) word[8*(first+k) +: 8] = wd[8*(first+k) +: 8];
               model[idx] = word;
            end
         end
         expQ.push_back(e);
      end
      n = 0;
      @(negedge hclk);
      while (!hreadyout && n < 100) begin
         @(negedge hclk);
         n++;
      end
      if (n >= 100) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL addrPhaseTimeout: hreadyout got 0, expected 1");
      end
      @(posedge hclk);
      #1;
      hwdata = w ? wd : $urandom();
   endtask

   task automatic idleBus(input int n);
      hsel   = 1'b0;
      htrans = 2'b00;
      repeat (n) @(posedge hclk);
      #1;
   endtask

   // Monitor: watches accepted address phases and checks each data phase as it completes.
   initial begin : monitor
      bit   active;
      int   lows;
      bit   respOk;
      exp_t e;
      active = 1'b0;
      lows   = 0;
      respOk = 1'b1;
      e      = '{err: 1'b0, rdata: 32'h0, waits: 0};
      forever begin
         @(negedge hclk);
         if (!hresetn) begin
            checkOutput("rstReadyout", 32'(hreadyout), 32'h1);
            checkOutput("rstResp", 32'(hresp), 32'h0);
            checkOutput("rstRdata", hrdata, 32'h0);
            if (active && expQ.size() > 0) void'(expQ.pop_front());
            active = 1'b0;
            continue;
         end
         if (active) begin
            if (!hreadyout) begin
               lows++;
               if (hresp !== e.err) respOk = 1'b0;
               if (lows > 50) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL dataPhaseTimeout: hreadyout got 0, expected 1");
                  active = 1'b0;
               end
            end else begin
               checkOutput("resp", 32'(hresp), 32'(e.err));
               checkOutput("rdata", hrdata, e.rdata);
               checkOutput("waitCycles", 32'(lows), 32'(e.waits));
               checkOutput("lowPhaseResp", 32'(respOk), 32'h1);
               active = 1'b0;
            end
         end else begin
            checkOutput("idleReadyResp", 32'({hreadyout, hresp}), 32'h2);
            checkOutput("idleRdata", hrdata, 32'h0);
         end
         if (hsel && hready && htrans[1]) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpectedAccept: queue got 0 entries, expected 1");
            end else begin
               e      = expQ.pop_front();
               active = 1'b1;
               lows   = 0;
               respOk = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation got no end, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] a;
      logic [2:0]  s;
      logic [1:0]  t;
      int          r;
      hresetn = 1'b0;
      hsel    = 1'b0;
      haddr   = 32'h0;
      htrans  = 2'b00;
      hwrite  = 1'b0;
      hsize   = 3'd0;
      hburst  = 3'd0;
      hwdata  = 32'h0;
      repeat (3) @(posedge hclk);
      #1;
      hresetn = 1'b1;
      idleBus(2);

      for (int i = 0; i < DEPTH; i++) applyStimulus(BASE + 32'(4*i), 1'b1, 3'd2, 2'b10, $urandom(), 1'b1, 1'b1);
      idleBus(3);

      applyStimulus(BASE + 32'd8, 1'b1, 3'd2, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd8, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);
      idleBus(2);

      applyStimulus(BASE + 32'd4, 1'b1, 3'd2, 2'b10, 32'h1122_3344, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd5, 1'b1, 3'd0, 2'b10, 32'h0000_5A00, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd4, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);
      idleBus(2);

      applyStimulus(BASE + 32'd2, 1'b1, 3'd2, 2'b10, 32'hFFFF_FFFF, 1'b1, 1'b1);
      idleBus(1);
      applyStimulus(BASE + 32'(4*DEPTH), 1'b1, 3'd2, 2'b10, 32'hFFFF_FFFF, 1'b1, 1'b1);
      applyStimulus(BASE - 32'd4, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd0, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd4, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);
      idleBus(2);

      applyStimulus(BASE + 32'd0,  1'b1, 3'd2, 2'b10, 32'd1, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd4,  1'b1, 3'd2, 2'b11, 32'd2, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd8,  1'b1, 3'd2, 2'b01, 32'h0, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd8,  1'b1, 3'd2, 2'b11, 32'd3, 1'b1, 1'b1);
      applyStimulus(BASE + 32'd12, 1'b1, 3'd2, 2'b11, 32'd4, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(BASE + 32'(4*i), 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'h0, 1'b1, 1'b1);
      idleBus(2);

      applyStimulus(BASE + 32'd12, 1'b1, 3'd2, 2'b10, 32'hCAFE_F00D, 1'b1, 1'b0);
      hsel    = 1'b0;
      htrans  = 2'b00;
      hresetn = 1'b0;
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      idleBus(1);
      applyStimulus(BASE + 32'd12, 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);
      idleBus(2);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 7);
         s = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'($urandom_range(3, 7));
         a = BASE - 32'd8 + 32'($urandom_range(0, 4*DEPTH + 15));
         if ($urandom_range(0, 9) < 8 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
         r = $urandom_range(0, 9);
         t = (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r == 8) ? 2'b01 : 2'b00;
         applyStimulus(a, 1'($urandom_range(0, 1)), s, t, $urandom(), $urandom_range(0, 9) != 0, 1'b1);
         if ($urandom_range(0, 7) == 0) idleBus($urandom_range(1, 3));
      end
      for (int i = 0; i < DEPTH; i++) applyStimulus(BASE + 32'(4*i), 1'b0, 3'd2, 2'b10, 32'h0, 1'b1, 1'b1);

      idleBus(20);
      checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-lite responder for the bus side driven by the team's AHB master. Decodes an address window and serves single and incrementing-burst transfers from an internal word-organised memory. Supports a configurable number of wait states and a two-cycle ERROR response for illegal accesses. Sits on the slave side of the AHB interconnect, one instance per memory-mapped target.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of first memory word
MEM_DEPTH, 256, number of 32-bit words (power of two, >=4)
WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase (0..15)

Ports:
hclk  in  1  bus clock, all state on rising edge
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select from decoder
haddr  in  32  byte address (address phase)
htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  in  1  1=write, 0=read
hsize  in  3  0=byte, 1=halfword, 2=word
hburst  in  3  burst type (informational; not used for decode)
hwdata  in  32  write data (data phase)
hready  in  1  bus-wide ready (previous transfer complete)
hreadyout  out  1  this slave's ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, all address-phase registers cleared. Memory contents are not reset. Reset asserted mid-transfer abandons it; a pending write is not performed.
- Address phase accepted when hsel & hready & htrans[1]. haddr, hwrite, hsize are captured into registers. IDLE/BUSY transfers, or hsel=0, start no data phase; the response is OKAY with zero wait.
- Legality check at capture: error if hsize>2, halfword with haddr[0]=1, word with haddr[1:0]!=0, or haddr outside [ADDR_BASE, ADDR_BASE+4*MEM_DEPTH).
- FSM states:
  - IDLE: no data phase.
  - WAIT: counter counts down from WAIT_STATES; hreadyout=0.
  - DATA: hreadyout=1, transfer completes.
  - ERR1: hresp=1, hreadyout=0.
  - ERR2: hresp=1, hreadyout=1.
- Transitions on an accepted legal transfer: go to WAIT if WAIT_STATES>0, else DATA. WAIT goes to DATA when the counter reaches 1.
- Transitions on an accepted illegal transfer: go to ERR1, then ERR2. Error responses ignore WAIT_STATES.
- From DATA or ERR2: if a new transfer is accepted in the same cycle, enter its first state directly (back-to-back pipelining). Otherwise go to IDLE.
- Writes: hwdata is sampled in the DATA cycle. Memory is updated at the end of that cycle, byte lanes little-endian:
  - byte: lane haddr[1:0]
  - halfword: lanes {haddr[1],0} and {haddr[1],1}
  - word: all lanes
  Other lanes are unchanged. No write occurs on ERROR.
- Reads: hrdata = mem[word index of captured address], full 32-bit word, combinational from storage, during WAIT and DATA of a read. hrdata=0 in all other states.
- Read in the cycle after a write to the same word returns the newly written data. No stall is added.
- hsel deassertion during a data phase does not abort it.
- The master issuing IDLE after the ERR1 cycle is legal. The slave still completes ERR2 before any new transfer.
- Word index = (haddr-ADDR_BASE)>>2, log2(MEM_DEPTH) bits.

Test Plan:
- WAIT_STATES=0: word write 32'hDEAD_BEEF to ADDR_BASE+8, then read it -> hreadyout stays 1; the read data phase shows hrdata=32'hDEAD_BEEF, hresp=0.
- WAIT_STATES=2: single read -> hreadyout low exactly 2 cycles, then high for 1 cycle with the correct hrdata.
- Byte write 8'h5A to ADDR_BASE+5 over the word 32'h1122_3344 at ADDR_BASE+4 -> a subsequent read returns 32'h1122_5A44.
- Word access at ADDR_BASE+2, and access at ADDR_BASE+4*MEM_DEPTH -> each gives hresp=1/hreadyout=0, then hresp=1/hreadyout=1. Memory is unchanged.
- 4-beat INCR burst (NONSEQ, SEQ, BUSY, SEQ, SEQ) of writes 1,2,3,4 from ADDR_BASE, then read back -> the BUSY cycle gets an OKAY zero-wait response, and reads return 1,2,3,4.
- Assert hresetn low during the WAIT phase of a write -> outputs go to reset values immediately. A later read of that address shows the old data.
